mux_nto1_scan: RTL and testbench
================================

// Module: mux_nto1_scan
// PURPOSE
//  Parametrised N:1 word multiplexer with a registered, handshaked output and two select modes.
//  - MANUAL: the channel is chosen by s.
//  - SCAN: channels are visited round-robin, dwelling a fixed number of accepted beats on each.
//  Sits between parallel sensor/data lanes and a single downstream consumer.
//  Successor to the combinational 4:1 selector: generalised width/channel count, adds scan mode and backpressure.
// PARAMETERS
//  WIDTH     8   data bits per channel
//  CHANNELS  4   number of input channels (>=2, need not be a power of 2)
//  DWELL     4   accepted beats per channel in SCAN mode (>=1)
//  SEL_W     localparam = clog2(CHANNELS), minimum 1
// PORTS
//  clk       in   1                 single clock, rising edge
//  rst       in   1                 synchronous, active-high reset
//  i         in   CHANNELS*WIDTH    packed channel data; channel k = i[k*WIDTH +: WIDTH]
//  in_valid  in   CHANNELS          per-channel data-valid
//  s         in   SEL_W             manual channel select
//  mode      in   1                 0 = MANUAL, 1 = SCAN
//  hold      in   1                 SCAN only: freeze pointer and dwell count
//  y         out  WIDTH             registered selected data
//  y_valid   out  1                 y holds a valid beat
//  y_ch      out  SEL_W             channel index that produced y
//  y_ready   in   1                 downstream accepts beat when y_valid && y_ready
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - y=0, y_valid=0, y_ch=0, ptr=0, dwell=0, state=MANUAL.
//   - Reset mid-operation discards any pending beat; it is not delivered.
//  Load rule:
//   - load = !y_valid || y_ready.
//   - On load: y <= data[cur], y_valid <= in_valid[cur], y_ch <= cur.
//   - Without load: y, y_valid, y_ch, ptr and dwell all hold (full stall).
//   - Latency: input to y is one cycle when not stalled.
//  cur = s in MANUAL, ptr in SCAN.
//  Out-of-range cur (s >= CHANNELS, non-pow2 only): on load y <= 0, y_valid <= 0, y_ch <= s.
//  FSM states: MANUAL, SCAN.
//   - MANUAL -> SCAN when mode=1: ptr <= s (0 if s is out of range), dwell <= 0.
//     Ptr is seeded in the transition cycle; the first SCAN-mode load uses the seeded ptr.
//   - SCAN -> MANUAL when mode=0: ptr and dwell hold their values but are unused.
//   - Mode is sampled every cycle; the transition takes effect on the next posedge.
//   - The output register is never flushed on a mode change.
//  SCAN advance (only on a load cycle with hold=0):
//   - dwell == DWELL-1: dwell <= 0; ptr <= (ptr == CHANNELS-1) ? 0 : ptr+1.
//   - otherwise: dwell <= dwell+1.
//   - Load cycles whose y_valid result is 0 still count toward dwell (time-slotted, not data-slotted).
//  hold=1 in SCAN: ptr and dwell frozen; loads continue from the same channel.
//  Simultaneous events:
//   - rst has priority over everything.
//   - A stall (load=0) has priority over the mode transition for ptr/dwell updates;
//     the state register still changes.
//  Widths: dwell counter clog2(DWELL) bits, minimum 1; wrap uses explicit compare, never overflow.
// STRUCTURE
//  Shared package mux_pkg:
//   - mode encoding constants MODE_MANUAL=1'b0, MODE_SCAN=1'b1;
//   - state encoding ST_MANUAL, ST_SCAN;
//   - clog2 helper function.
//  One sub-module, mux_scan_ptr: owns ptr and dwell.
//   - Inputs: clk, rst, seed, seed_en, adv_en, hold.
//   - Output: ptr.
//  Top level holds the FSM, the combinational N:1 select and the output register.
// TESTING
//  1 Reset: assert rst 2 cycles with i nonzero -> y=0, y_valid=0, y_ch=0 next cycle.
//  2 MANUAL: W=8, C=4, y_ready=1, in_valid=4'hF, i={8'hD4,8'hC3,8'hB2,8'hA1}, s=2
//    -> y=8'hC3, y_ch=2 one cycle later; s=3 -> y=8'hD4 next cycle.
//  3 SCAN DWELL=4, from s=1, y_ready=1 -> y_ch sequence 1,1,1,1,2,2,2,2,3,3,3,3,0,...
//  4 Backpressure: y_ready=0 for 3 cycles mid-dwell -> y, y_ch, ptr, dwell unchanged;
//    the scan sequence resumes exactly on release.
//  5 hold=1 in SCAN for 6 cycles on ch2 -> y_ch=2 throughout; dwell resumes from its frozen count.
//  6 Non-pow2 C=3, SCAN -> ptr wraps 2->0; MANUAL s=3 -> y=0, y_valid=0, y_ch=3.
//    Also: rst asserted with y_valid=1 and y_ready=0 -> beat dropped, outputs return to reset values.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the N:1 scan multiplexer: mode and state encodings
// plus a width helper used to size the select and dwell counters.
package mux_pkg;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   typedef enum logic [0:0] {
      ST_MANUAL = 1'b0,
      ST_SCAN   = 1'b1
   } state_t;

   // Ceiling log2 clamped to at least 1 so single-value counters still get a bit.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((32'sd1 << r) < n) begin
         r = r + 32'sd1;
      end
      return (r < 32'sd1) ? 32'sd1 : r;
   endfunction

endpackage

// File: rtl/mux_scan_ptr.sv
// Round-robin channel pointer with per-channel dwell counter for SCAN mode.
// Seeding wins over advancing; hold freezes both pointer and dwell.
module mux_scan_ptr
   import mux_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int DWELL    = 4,
   parameter int SEL_W    = clog2(CHANNELS),
   parameter int DW_W     = clog2(DWELL)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [SEL_W-1:0] seed,
   input  logic             seed_en,
   input  logic             adv_en,
   input  logic             hold,
   output logic [SEL_W-1:0] ptr
);

   localparam logic [SEL_W:0]   CH_CNT   = (SEL_W+1)'(CHANNELS);
   localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(CHANNELS - 1);
   localparam logic [DW_W-1:0]  LAST_DW  = DW_W'(DWELL - 1);

   logic [SEL_W-1:0] ptr_r;
   logic [DW_W-1:0]  dwell_r;
   logic [SEL_W-1:0] seed_s;
   logic [SEL_W-1:0] ptr_nxt_s;
   logic             dwell_last_s;

   // Sanitised seed, wrapped pointer increment and dwell terminal detect.
   always_comb begin
      seed_s       = {SEL_W{1'b0}};
      ptr_nxt_s    = {SEL_W{1'b0}};
      dwell_last_s = 1'b0;
      if ({1'b0, seed} < CH_CNT) begin
         seed_s = seed;
      end else begin
         seed_s = {SEL_W{1'b0}};
      end
      if (ptr_r == LAST_CH) begin
         ptr_nxt_s = {SEL_W{1'b0}};
      end else begin
         ptr_nxt_s = ptr_r + SEL_W'(1);
      end
      dwell_last_s = (dwell_r == LAST_DW);
   end

   // Pointer and dwell state: seed on entry to SCAN, advance on unheld load beats.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_r   <= {SEL_W{1'b0}};
         dwell_r <= {DW_W{1'b0}};
      end else if (seed_en) begin
         ptr_r   <= seed_s;
         dwell_r <= {DW_W{1'b0}};
      end else if (adv_en && !hold) begin
         if (dwell_last_s) begin
            ptr_r   <= ptr_nxt_s;
            dwell_r <= {DW_W{1'b0}};
         end else begin
            ptr_r   <= ptr_r;
            dwell_r <= dwell_r + DW_W'(1);
         end
      end else begin
         ptr_r   <= ptr_r;
         dwell_r <= dwell_r;
      end
   end

   assign ptr = ptr_r;

endmodule

// File: rtl/mux_nto1_scan.sv
// N:1 word multiplexer with a registered valid/ready output stage, selecting
// either a manual channel or a round-robin scan pointer.
module mux_nto1_scan
   import mux_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int DWELL    = 4,
   localparam int SEL_W   = clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS*WIDTH-1:0] i,
   input  logic [CHANNELS-1:0]       in_valid,
   input  logic [SEL_W-1:0]          s,
   input  logic                      mode,
   input  logic                      hold,
   output logic [WIDTH-1:0]          y,
   output logic                      y_valid,
   output logic [SEL_W-1:0]          y_ch,
   input  logic                      y_ready
);

   state_t           state_r;
   logic [SEL_W-1:0] ptr_s;
   logic [SEL_W-1:0] cur_s;
   logic [WIDTH-1:0] sel_data_s;
   logic             sel_valid_s;
   logic             load_s;
   logic             seed_en_s;
   logic             adv_en_s;
   logic [WIDTH-1:0] y_r;
   logic             y_valid_r;
   logic [SEL_W-1:0] y_ch_r;

   mux_scan_ptr #(
      .CHANNELS (CHANNELS),
      .DWELL    (DWELL),
      .SEL_W    (SEL_W)
   ) u_scan_ptr (
      .clk     (clk),
      .rst     (rst),
      .seed    (s),
      .seed_en (seed_en_s),
      .adv_en  (adv_en_s),
      .hold    (hold),
      .ptr     (ptr_s)
   );

   // Current channel and handshake-derived control strobes.
   always_comb begin
      cur_s = s;
      case (state_r)
         ST_SCAN:   cur_s = ptr_s;
         ST_MANUAL: cur_s = s;
         default:   cur_s = s;
      endcase
      load_s    = !y_valid_r || y_ready;
      seed_en_s = load_s && (state_r == ST_MANUAL) && (mode == MODE_SCAN);
      adv_en_s  = load_s && (state_r == ST_SCAN);
   end

   // AND-OR select; an out-of-range index matches nothing and yields zero data, invalid.
   always_comb begin
      sel_data_s  = {WIDTH{1'b0}};
      sel_valid_s = 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
         sel_data_s  = sel_data_s | (i[k*WIDTH +: WIDTH] & {WIDTH{cur_s == SEL_W'(k)}});
         sel_valid_s = sel_valid_s | (in_valid[k] & (cur_s == SEL_W'(k)));
      end
   end

   // Mode FSM; the state follows mode even while the output stage is stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_MANUAL;
      end else begin
         case (state_r)
            ST_MANUAL: begin
               if (mode == MODE_SCAN) begin
                  state_r <= ST_SCAN;
               end else begin
                  state_r <= ST_MANUAL;
               end
            end
            ST_SCAN: begin
               if (mode == MODE_MANUAL) begin
                  state_r <= ST_MANUAL;
               end else begin
                  state_r <= ST_SCAN;
               end
            end
            default: state_r <= ST_MANUAL;
         endcase
      end
   end

   // Output register: loads when empty or drained, otherwise holds the pending beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         y_r       <= {WIDTH{1'b0}};
         y_valid_r <= 1'b0;
         y_ch_r    <= {SEL_W{1'b0}};
      end else if (load_s) begin
         y_r       <= sel_data_s;
         y_valid_r <= sel_valid_s;
         y_ch_r    <= cur_s;
      end else begin
         y_r       <= y_r;
         y_valid_r <= y_valid_r;
         y_ch_r    <= y_ch_r;
      end
   end

   assign y       = y_r;
   assign y_valid = y_valid_r;
   assign y_ch    = y_ch_r;

endmodule

// File: tb/tb_mux_nto1_scan.sv
// Bench for mux_nto1_scan: a 4-channel/DWELL=4 and a 3-channel/DWELL=2 instance
// share stimulus and are both tracked by a beat-level reference model.
module tb_mux_nto1_scan;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] i_bus;
   logic [3:0]  in_valid;
   logic [1:0]  s;
   logic        mode;
   logic        hold;
   logic        y_ready;

   logic [7:0]  y0, y1;
   logic        yv0, yv1;
   logic [1:0]  ych0, ych1;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [7:0] y;
      bit         yv;
      int         ych;
      int         ptr;
      int         dw;
      bit         scan;
   } mst_t;

   mst_t m0, m1;

   always #5 clk = ~clk;

   mux_nto1_scan #(.WIDTH(8), .CHANNELS(4), .DWELL(4)) dut (
      .clk(clk), .rst(rst), .i(i_bus), .in_valid(in_valid), .s(s), .mode(mode),
      .hold(hold), .y(y0), .y_valid(yv0), .y_ch(ych0), .y_ready(y_ready)
   );

   mux_nto1_scan #(.WIDTH(8), .CHANNELS(3), .DWELL(2)) dut3 (
      .clk(clk), .rst(rst), .i(i_bus[23:0]), .in_valid(in_valid[2:0]), .s(s), .mode(mode),
      .hold(hold), .y(y1), .y_valid(yv1), .y_ch(ych1), .y_ready(y_ready)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock edge of the documented behaviour, expressed per beat.
   function automatic mst_t step(input mst_t st, input int c, input int d);
      mst_t n;
      bit   load;
      int   cur;
      n = st;
      if (rst) begin
         n.y = 8'h00; n.yv = 1'b0; n.ych = 0; n.ptr = 0; n.dw = 0; n.scan = 1'b0;
         return n;
      end
      load = !st.yv || y_ready;
      cur  = st.scan ? st.ptr : int'(s);
      if (load) begin
         n.ych = cur;
         if (cur < c) begin
            n.y  = i_bus[cur*8 +: 8];
            n.yv = in_valid[cur];
         end else begin
            n.y  = 8'h00;
            n.yv = 1'b0;
         end
         if (!st.scan && mode) begin
            n.ptr = (int'(s) < c) ? int'(s) : 0;
            n.dw  = 0;
         end else if (st.scan && !hold) begin
            n.dw = st.dw + 1;
            if (n.dw == d) begin
               n.dw  = 0;
               n.ptr = (st.ptr + 1) % c;
            end
         end
      end
      n.scan = mode;
      return n;
   endfunction

   // Model update on every rising edge, compare just after it.
   initial begin
      forever begin
         @(posedge clk);
         m0 = step(m0, 4, 4);
         m1 = step(m1, 3, 2);
         #1;
         check("model_y_c4",   {24'h0, y0},   {24'h0, m0.y});
         check("model_yv_c4",  {31'h0, yv0},  {31'h0, m0.yv});
         check("model_ych_c4", {30'h0, ych0}, 32'(m0.ych));
         check("model_y_c3",   {24'h0, y1},   {24'h0, m1.y});
         check("model_yv_c3",  {31'h0, yv1},  {31'h0, m1.yv});
         check("model_ych_c3", {30'h0, ych1}, 32'(m1.ych));
      end
   end

   int exp_scan[13]  = '{1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 0};
   int exp_seq[18]   = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 3};
   int exp_c3[7]     = '{0, 0, 1, 1, 2, 2, 0};
   logic [31:0] dat4 = 32'hD4C3B2A1;

   initial begin
      rst = 1'b1; i_bus = 32'hD4C3B2A1; in_valid = 4'hF; s = 2'd0;
      mode = 1'b0; hold = 1'b0; y_ready = 1'b1;

      // Reset held two cycles with live data.
      repeat (2) @(negedge clk);
      check("rst_y",   {24'h0, y0},   32'h0);
      check("rst_yv",  {31'h0, yv0},  32'h0);
      check("rst_ych", {30'h0, ych0}, 32'h0);
      rst = 1'b0;

      // Manual selection.
      s = 2'd2;
      @(negedge clk);
      check("man_y_s2",   {24'h0, y0},   32'hC3);
      check("man_ych_s2", {30'h0, ych0}, 32'd2);
      check("man_yv_s2",  {31'h0, yv0},  32'd1);
      s = 2'd3;
      @(negedge clk);
      check("man_y_s3", {24'h0, y0}, 32'hD4);

      // Scan from channel 1; first edge is the manual-state seeding load.
      s = 2'd1; mode = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 13; k++) begin
         @(negedge clk);
         check("scan_seq_ych", {30'h0, ych0}, 32'(exp_scan[k]));
      end

      // Backpressure mid-dwell on channel 0.
      y_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("stall_ych", {30'h0, ych0}, 32'd0);
         check("stall_y",   {24'h0, y0},   32'hA1);
      end
      y_ready = 1'b1;

      // Resume, reach channel 2, hold six cycles, then resume dwell.
      for (int k = 0; k < 18; k++) begin
         if (k == 7) hold = 1'b1;
         if (k == 13) hold = 1'b0;
         @(negedge clk);
         check("resume_hold_ych", {30'h0, ych0}, 32'(exp_seq[k]));
         check("resume_hold_y",   {24'h0, y0},   {24'h0, dat4[exp_seq[k]*8 +: 8]});
      end

      // Three-channel instance: scan wrap 2->0, then out-of-range manual select.
      rst = 1'b1; mode = 1'b0; s = 2'd0;
      @(negedge clk);
      rst = 1'b0; mode = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         check("c3_scan_ych", {30'h0, ych1}, 32'(exp_c3[k]));
      end
      mode = 1'b0; s = 2'd3;
      repeat (2) @(negedge clk);
      check("c3_oor_y",   {24'h0, y1},   32'h0);
      check("c3_oor_yv",  {31'h0, yv1},  32'h0);
      check("c3_oor_ych", {30'h0, ych1}, 32'd3);
      check("c4_s3_y",    {24'h0, y0},   32'hD4);

      // Pending beat discarded by reset.
      y_ready = 1'b0; s = 2'd1;
      @(negedge clk);
      check("pend_yv", {31'h0, yv1}, 32'd1);
      check("pend_y",  {24'h0, y1},  32'hB2);
      rst = 1'b1;
      @(negedge clk);
      check("drop_y",   {24'h0, y1},   32'h0);
      check("drop_yv",  {31'h0, yv1},  32'h0);
      check("drop_ych", {30'h0, ych1}, 32'h0);
      rst = 1'b0; y_ready = 1'b1;

      // Randomised traffic against the model.
      for (int n = 0; n < 4000; n++) begin
         i_bus    = $urandom;
         in_valid = 4'($urandom);
         s        = 2'($urandom);
         if ($urandom_range(15, 0) == 0) mode = ~mode;
         hold     = ($urandom_range(3, 0) == 0);
         y_ready  = ($urandom_range(2, 0) != 0);
         rst      = ($urandom_range(63, 0) == 0);
         @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
